// File: rtl/frame_detect_scheduler_if.sv
// Requester-side bundle of the frame detect scheduler: requests, words, grant,
// completion pulse and match result.
interface frame_detect_scheduler_if;
    logic [3:0]  req;
    logic [15:0] data;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic        result;

    modport master (output req, data, input gnt, ack, result);
    modport slave  (input req, data, output gnt, ack, result);
endinterface

// File: rtl/frame_detect_scheduler.sv
// Round-robin sharing of one 4-bit-frame Mealy sequence detector among four
// requesters; each frame is serialised MSB-first after a detector resync.
module frame_detect_scheduler (
    input  logic                     clk,
    input  logic                     rst,
    frame_detect_scheduler_if.slave  bus,
    output logic                     busy,
    output logic [7:0]               match_cnt,
    input  logic                     cnt_clr,
    output logic                     det_in,
    output logic                     det_rst_n,
    input  logic                     det_dec
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SYNC = 3'd1,
        BIT3 = 3'd2,
        BIT2 = 3'd3,
        BIT1 = 3'd4,
        BIT0 = 3'd5,
        RESP = 3'd6
    } state_t;

    state_t      state_r;
    logic [1:0]  ptr_r;
    logic [3:0]  word_r;
    logic [3:0]  gnt_r;
    logic [3:0]  ack_r;
    logic        result_r;
    logic        busy_r;
    logic        det_in_r;
    logic        det_rst_n_r;
    logic [7:0]  match_cnt_r;
    logic [1:0]  win_s;
    logic [3:0]  win_onehot_s;

    // First set request scanning upward from the pointer, modulo 4.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [1:0] idx;
        logic [1:0] win;
        logic       found;
        win   = ptr;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr + i[1:0];
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

    // Winner selection for the current pointer.
    always_comb begin
        win_s        = rr_pick(bus.req, ptr_r);
        win_onehot_s = 4'b0001 << win_s;
    end

    // Frame FSM with registered outputs, plus the saturating match counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            ptr_r       <= 2'd0;
            word_r      <= 4'd0;
            gnt_r       <= 4'd0;
            ack_r       <= 4'd0;
            result_r    <= 1'b0;
            busy_r      <= 1'b0;
            det_in_r    <= 1'b0;
            det_rst_n_r <= 1'b1;
            match_cnt_r <= 8'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (|bus.req) begin
                        state_r     <= SYNC;
                        ptr_r       <= win_s + 2'd1;
                        word_r      <= bus.data[{win_s, 2'b00} +: 4];
                        gnt_r       <= win_onehot_s;
                        busy_r      <= 1'b1;
                        det_rst_n_r <= 1'b0;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SYNC: begin
                    state_r     <= BIT3;
                    det_rst_n_r <= 1'b1;
                    det_in_r    <= word_r[3];
                end
                BIT3: begin
                    state_r  <= BIT2;
                    det_in_r <= word_r[2];
                end
                BIT2: begin
                    state_r  <= BIT1;
                    det_in_r <= word_r[1];
                end
                BIT1: begin
                    state_r  <= BIT0;
                    det_in_r <= word_r[0];
                end
                BIT0: begin
                    // Mealy output is valid while the last bit is presented.
                    state_r  <= RESP;
                    det_in_r <= 1'b0;
                    result_r <= det_dec;
                    ack_r    <= gnt_r;
                end
                RESP: begin
                    state_r  <= IDLE;
                    ack_r    <= 4'd0;
                    result_r <= 1'b0;
                    gnt_r    <= 4'd0;
                    busy_r   <= 1'b0;
                end
                default: begin
                    state_r     <= IDLE;
                    ack_r       <= 4'd0;
                    result_r    <= 1'b0;
                    gnt_r       <= 4'd0;
                    busy_r      <= 1'b0;
                    det_in_r    <= 1'b0;
                    det_rst_n_r <= 1'b1;
                end
            endcase

            if (cnt_clr) begin
                match_cnt_r <= 8'd0;
            end else if ((state_r == RESP) && result_r && (match_cnt_r != 8'hFF)) begin
                match_cnt_r <= match_cnt_r + 8'd1;
            end else begin
                match_cnt_r <= match_cnt_r;
            end
        end
    end

    assign bus.gnt    = gnt_r;
    assign bus.ack    = ack_r;
    assign bus.result = result_r;
    assign busy       = busy_r;
    assign match_cnt  = match_cnt_r;
    assign det_in     = det_in_r;
    assign det_rst_n  = det_rst_n_r & ~rst;

endmodule
